// File: rtl/mem_access_unit.sv
// mem_access_unit: word-aligned load/store sequencer with setup/access/hold phases and address checking
module mem_access_unit #(
    parameter int MEM_AW = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic [7:0]  err_count
);
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, ERR} state_t;
    state_t state;
    logic   wr;
    logic   bad;
    assign req_ready = state == IDLE;
    assign bad = req_addr[1:0] != 2'b00 || (req_addr >> (MEM_AW + 2)) != 32'd0;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr         <= 1'b0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= 32'd0;
            mem_ren    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= 32'd0;
            mem_din    <= 32'd0;
            err_count  <= 8'd0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    if (bad) begin
                        state      <= ERR;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        err_count  <= err_count == 8'hff ? err_count : err_count + 8'd1;
                    end else begin
                        state    <= SETUP;
                        wr       <= req_write;
                        mem_addr <= {2'b00, req_addr[31:2]};
                        mem_din  <= req_wdata;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    mem_wen <= wr;
                    mem_ren <= !wr;
                end
                ACCESS: begin
                    state      <= HOLD;
                    mem_wen    <= 1'b0;
                    mem_ren    <= 1'b0;
                    resp_valid <= 1'b1;
                    if (!wr) resp_rdata <= mem_dout;
                end
                HOLD: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
                ERR: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table, directed and random checks of mem_access_unit against a transaction-level model
module tb_mem_access_unit;
    localparam int AW = 12;
    logic        clock = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_error, mem_ren, mem_wen;
    logic [31:0] resp_rdata, mem_addr, mem_din, mem_dout;
    logic [7:0]  err_count;
    logic [31:0] mem [0:4095] = '{default: 32'h0};

    mem_access_unit #(.MEM_AW(AW)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .err_count(err_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) if (mem_wen) mem[mem_addr[11:0]] <= mem_din;
    assign mem_dout = mem_ren ? mem[mem_addr[11:0]] : 32'h0;

    int tests = 0, fails = 0;
    int m_err = 0;
    logic [31:0] m_maddr = 0, m_mdin = 0, m_rd = 0;
    logic [31:0] ref_mem [int];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t tv [8];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", n, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_of(input logic [31:0] idx);
        return ref_mem.exists(int'(idx)) ? ref_mem[int'(idx)] : 32'h0;
    endfunction

    // One request end to end; expectations come from address rules and the word-level model
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic obs_err, output logic [31:0] obs_rd);
        logic bad;
        logic [31:0] idx, new_rd;
        int n;
        bad = a[1:0] != 2'b00 || a >= (32'd1 << (AW + 2));
        idx = a / 4;
        new_rd = (!bad && !w) ? rd_of(idx) : m_rd;
        obs_err = 1'b0;
        obs_rd = 'x;
        @(negedge clock);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("accept_wait", {31'd0, req_ready}, 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        if (!bad) begin
            m_maddr = idx;
            m_mdin = d;
            if (w) ref_mem[int'(idx)] = d;
        end else m_err = m_err == 255 ? 255 : m_err + 1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            if (i == 1) begin
                req_valid = 1'b0; req_write = ~w; req_addr = $urandom; req_wdata = $urandom;
            end
            chk("resp_valid", {31'd0, resp_valid}, {31'd0, i == (bad ? 1 : 3)});
            chk("resp_error", {31'd0, resp_error}, {31'd0, bad && i == 1});
            chk("mem_wen", {31'd0, mem_wen}, {31'd0, !bad && w && i == 2});
            chk("mem_ren", {31'd0, mem_ren}, {31'd0, !bad && !w && i == 2});
            chk("req_ready", {31'd0, req_ready}, {31'd0, bad ? i >= 2 : i == 4});
            chk("mem_addr", mem_addr, m_maddr);
            chk("mem_din", mem_din, m_mdin);
            chk("resp_rdata", resp_rdata, (!bad && !w && i >= 3) ? new_rd : m_rd);
            if (resp_valid) obs_err = resp_error;
        end
        chk("err_count", {24'd0, err_count}, m_err);
        if (!bad && w) chk("mem_word", mem[idx[11:0]], d);
        m_rd = new_rd;
        obs_rd = resp_rdata;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic e;
        logic [31:0] r, a, pa;
        int acc [3];
        int k, last;
        logic upd;
        tv[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tv[1] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tv[2] = '{1'b1, 32'h0000_0012, 32'h5555_5555, 1'b1, 32'hDEAD_BEEF};
        tv[3] = '{1'b0, 32'h0001_0000, 32'h0,         1'b1, 32'hDEAD_BEEF};
        tv[4] = '{1'b1, 32'h0000_3FFC, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF};
        tv[5] = '{1'b0, 32'h0000_3FFC, 32'h0,         1'b0, 32'hCAFE_F00D};
        tv[6] = '{1'b0, 32'h0000_4000, 32'h0,         1'b1, 32'hCAFE_F00D};
        tv[7] = '{1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h0};

        #2 reset = 1'b0;
        #1;
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_error", {31'd0, resp_error}, 32'd0);
        chk("rst_en", {30'd0, mem_ren, mem_wen}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_din", mem_din, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_errcnt", {24'd0, err_count}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clock);
        reset = 1'b1;

        foreach (tv[j]) begin
            do_req(tv[j].w, tv[j].a, tv[j].d, e, r);
            chk("tbl_err", {31'd0, e}, {31'd0, tv[j].exp_err});
            chk("tbl_rdata", r, tv[j].exp_rd);
        end
        chk("tbl_errcnt", {24'd0, err_count}, 32'd3);

        // Back-to-back stores with req_valid held high
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'h1111_0000;
        k = 0; last = -10; upd = 1'b0; pa = mem_addr;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clock);
            if (upd) begin
                upd = 1'b0;
                if (k == 3) req_valid = 1'b0;
                else begin
                    req_addr = 32'(k * 4);
                    req_wdata = 32'h1111_0000 + 32'(k);
                end
            end
            if (mem_ren || mem_wen) chk("b2b_addr_stable", mem_addr, pa);
            pa = mem_addr;
            if (i - last >= 1 && i - last <= 3) chk("b2b_ready", {31'd0, req_ready}, 32'd0);
            if (req_valid && req_ready && k < 3) begin
                acc[k] = i;
                last = i;
                k++;
                upd = 1'b1;
            end
        end
        chk("b2b_count", k, 3);
        chk("b2b_gap1", acc[1] - acc[0], 4);
        chk("b2b_gap2", acc[2] - acc[1], 4);
        for (int j = 0; j < 3; j++) begin
            ref_mem[j] = 32'h1111_0000 + 32'(j);
            chk("b2b_mem", mem[j], 32'h1111_0000 + 32'(j));
        end
        m_maddr = 32'd2;
        m_mdin = 32'h1111_0002;

        for (int j = 0; j < 200; j++) begin
            case ($urandom_range(0, 3))
                0, 1: a = 32'($urandom_range(0, 4095)) << 2;
                2: a = (32'($urandom_range(0, 4095)) << 2) | 32'($urandom_range(1, 3));
                default: a = $urandom | 32'h0000_4000;
            endcase
            do_req(1'($urandom_range(0, 1)), a, $urandom, e, r);
        end

        for (int j = 0; j < 260; j++) do_req(1'(j % 2), j % 2 ? 32'h0000_0012 : 32'h0001_0000, 32'h0, e, r);
        chk("err_saturate", {24'd0, err_count}, 32'd255);

        // Reset asserted in the middle of a store's ACCESS cycle
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        chk("mid_wen", {31'd0, mem_wen}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort_wen", {31'd0, mem_wen}, 32'd0);
        chk("abort_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_errcnt", {24'd0, err_count}, 32'd0);
        chk("abort_addr", mem_addr, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        m_err = 0; m_maddr = 0; m_mdin = 0; m_rd = 0;
        repeat (3) begin
            @(negedge clock);
            chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        chk("abort_mem", mem[8], rd_of(32'd8));
        do_req(1'b0, 32'h20, 32'h0, e, r);
        chk("post_reset_load", r, rd_of(32'd8));
        chk("post_reset_err", {31'd0, e}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: MEM_AW, default 12, width of memory word index driven on mem_addr LSBs.
REQ-002 clock  input  1  system clock; all state updates on posedge clock.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  requester presents a memory request.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_write  input  1  1 = store word, 0 = load word.
REQ-007 req_addr  input  32  byte address of the access.
REQ-008 req_wdata  input  32  store data.
REQ-009 resp_valid  output  1  one-cycle pulse: access complete.
REQ-010 resp_error  output  1  qualifies resp_valid: request rejected, no memory access made.
REQ-011 resp_rdata  output  32  load data, valid with resp_valid for non-error loads.
REQ-012 mem_ren  output  1  memory read enable.
REQ-013 mem_wen  output  1  memory write enable.
REQ-014 mem_addr  output  32  memory word index.
REQ-015 mem_din  output  32  memory write data.
REQ-016 mem_dout  input  32  memory read data, combinational from mem_addr while mem_ren=1.
REQ-017 err_count  output  8  number of rejected requests, saturating.

Function
REQ-018 The unit SHALL implement FSM states IDLE, SETUP, ACCESS, HOLD, ERR; all outputs except req_ready SHALL be registered.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on a posedge with req_valid=1 and req_ready=1.
REQ-020 On accept, the unit SHALL latch req_write, req_wdata and the word index {2'b00, req_addr[31:2]}; req_* may change afterwards.
REQ-021 A request SHALL be rejected if req_addr[1:0]!=0 or req_addr[31:MEM_AW+2]!=0; accept then goes IDLE->ERR.
REQ-022 Valid request: IDLE->SETUP->ACCESS->HOLD->IDLE, one cycle per state.
REQ-023 SETUP: mem_addr and mem_din driven with latched values, mem_ren=mem_wen=0.
REQ-024 ACCESS: mem_addr/mem_din unchanged; mem_wen=1 for stores or mem_ren=1 for loads, never both.
REQ-025 For loads, resp_rdata SHALL capture mem_dout on the posedge ending ACCESS.
REQ-026 HOLD: mem_ren=mem_wen=0, mem_addr/mem_din still held; resp_valid=1, resp_error=0.
REQ-027 resp_rdata SHALL hold its last load value until the next load completes; stores SHALL NOT modify it.
REQ-028 ERR: resp_valid=1, resp_error=1, mem_ren=mem_wen=0, mem_addr/mem_din unchanged, err_count+1 saturating at 255; next state IDLE.
REQ-029 resp_valid SHALL be 0 in all states other than HOLD and ERR; resp_error SHALL be 0 outside ERR.
REQ-030 mem_addr/mem_din SHALL change only on the accept edge; never while an enable is 1 or in HOLD.
REQ-031 Latency: resp_valid in the 3rd cycle after the accept edge (valid) or 1st cycle (rejected); max throughput 1 request per 4 cycles (valid) / 2 cycles (rejected).
REQ-032 req_valid with req_ready=0 SHALL be ignored; the requester SHALL hold it until accepted.

Reset
REQ-033 reset=0 SHALL immediately force state IDLE, mem_ren=mem_wen=0, resp_valid=resp_error=0, mem_addr=mem_din=resp_rdata=0, err_count=0, independent of clock.
REQ-034 Reset during SETUP/ACCESS/HOLD/ERR SHALL abandon the access with no response pulse; after release the first posedge may accept a request.

Verification
REQ-035 Store addr 0x0000_0010 data 0xDEAD_BEEF -> SETUP mem_addr=0x4; ACCESS mem_wen=1, mem_ren=0; HOLD resp_valid=1, resp_error=0; memory word 4 = 0xDEADBEEF.
REQ-036 Load addr 0x0000_0010 after REQ-035 -> mem_ren=1 for one cycle only; resp_rdata=0xDEADBEEF with resp_valid, 3 cycles after accept.
REQ-037 Requests addr 0x0000_0012 and 0x0001_0000 -> each ERR: resp_valid=resp_error=1 one cycle after accept, enables never 1, err_count 0->1->2; 256 rejects -> err_count=255.
REQ-038 req_valid held high with back-to-back stores to 0x0,0x4,0x8 -> accepts 4 cycles apart; req_ready=0 in SETUP/ACCESS/HOLD; mem_addr stable whenever an enable is 1.
REQ-039 reset=0 asserted mid-ACCESS of a store -> mem_wen drops same time step, no resp_valid, err_count=0; new load after release completes normally.
